// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared FSM type, register map constants and reset defaults for the WM8731 responder
package wm8731_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_B1,
    ST_B1_ACK,
    ST_B2,
    ST_B2_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [6:0] R_LIN_L  = 7'h00;
  localparam logic [6:0] R_RIN_L  = 7'h01;
  localparam logic [6:0] R_LOUT_H = 7'h02;
  localparam logic [6:0] R_ROUT_H = 7'h03;
  localparam logic [6:0] R_APATH  = 7'h04;
  localparam logic [6:0] R_DPATH  = 7'h05;
  localparam logic [6:0] R_PWR    = 7'h06;
  localparam logic [6:0] R_IFACE  = 7'h07;
  localparam logic [6:0] R_SRATE  = 7'h08;
  localparam logic [6:0] R_ACTIVE = 7'h09;
  localparam logic [6:0] R_RESET  = 7'h0F;

  localparam int NUM_REGS = 10;
  localparam int FILT_LEN = 8;

  localparam logic [8:0] REG_DEFAULTS [NUM_REGS] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
// Optional stability filter on both lines when WM8731_RESP_GLITCH_FILTER_EN is defined.
module i2c_line_sync
  import wm8731_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl;
  logic       w_sda;

  // Idle bus is high on both lines, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef WM8731_RESP_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic       r_scl_flt;
  logic       r_sda_flt;
  logic [3:0] r_scl_cnt;
  logic [3:0] r_sda_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_flt <= 1'b1;
      r_sda_flt <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (r_scl_sync[1] == r_scl_flt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FILT_LAST) begin
        r_scl_flt <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end
      if (r_sda_sync[1] == r_sda_flt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FILT_LAST) begin
        r_sda_flt <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  // START/STOP need SCL steady high across the sample; a joint SCL+SDA change is a data bit.
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = ~w_sda & r_sda_prev & w_scl & r_scl_prev;
  assign o_stop     = w_sda & ~r_sda_prev & w_scl & r_scl_prev;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// rtl/wm8731_i2c_responder.sv - WM8731 control-port I2C write target holding shadow registers R0-R9
// Optional SCL/SDA glitch filter: define WM8731_RESP_GLITCH_FILTER_EN.
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic        oREG_WE,
  output logic [6:0]  oREG_ADDR,
  output logic [8:0]  oREG_DATA,
  output logic [89:0] oREGS,
  output logic        oACTIVE,
  output logic        oBUSY,
  output logic        oBAD_ADDR
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte1;
  logic       r_sda_oe;
  logic [8:0] r_regs [NUM_REGS];
  logic       r_reg_we;
  logic       r_bad_addr;
  logic [6:0] r_reg_addr;
  logic [8:0] r_reg_data;

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_shift_en;
  logic       w_cnt_clr;
  logic       w_byte1_ld;
  logic       w_commit;
  logic [6:0] w_wr_addr;
  logic [8:0] w_wr_data;

  i2c_line_sync u_line_sync (
    .i_clk      (iCLK),
    .i_rst      (iRST),
    .i_scl      (I2C_SCLK),
    .i_sda      (I2C_SDAT),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign I2C_SDAT  = r_sda_oe ? 1'b0 : 1'bz;
  assign w_wr_addr = r_byte1[7:1];
  assign w_wr_data = {r_byte1[0], r_shift};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_cnt_clr    = 1'b0;
    w_byte1_ld   = 1'b0;
    w_commit     = 1'b0;
    if (w_start) begin
      w_state_next = ST_DEV;
      w_cnt_clr    = 1'b1;
    end else if (w_stop) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_DEV, ST_B1, ST_B2: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_en = 1'b1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_cnt_clr = 1'b1;
            if (r_state == ST_DEV) begin
              w_state_next = (r_shift == {DEV_ADDR, 1'b0}) ? ST_DEV_ACK : ST_IGNORE;
            end else if (r_state == ST_B1) begin
              w_state_next = ST_B1_ACK;
              w_byte1_ld   = 1'b1;
            end else begin
              w_state_next = ST_B2_ACK;
            end
          end
        end
        ST_DEV_ACK: if (w_scl_fall) w_state_next = ST_B1;
        ST_B1_ACK:  if (w_scl_fall) w_state_next = ST_B2;
        ST_B2_ACK: begin
          if (w_scl_fall) begin
            w_state_next = ST_IGNORE;
            w_commit     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte1    <= '0;
      r_sda_oe   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_bad_addr <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_DEFAULTS[i];
    end else begin
      r_reg_we   <= 1'b0;
      r_bad_addr <= 1'b0;
      // SDA is pulled low exactly while the FSM sits in an ACK state.
      r_sda_oe   <= (w_state_next == ST_DEV_ACK) || (w_state_next == ST_B1_ACK) ||
                    (w_state_next == ST_B2_ACK);
      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_shift   <= {r_shift[6:0], w_sda};
      end
      if (w_byte1_ld) r_byte1 <= r_shift;
      if (w_commit) begin
        if (w_wr_addr < 7'(NUM_REGS)) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (w_wr_addr == 7'(i)) r_regs[i] <= w_wr_data;
          r_reg_we   <= 1'b1;
          r_reg_addr <= w_wr_addr;
          r_reg_data <= w_wr_data;
        end else if (w_wr_addr == R_RESET) begin
          for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_DEFAULTS[i];
          r_reg_we   <= 1'b1;
          r_reg_addr <= R_RESET;
          r_reg_data <= w_wr_data;
        end else begin
          r_bad_addr <= 1'b1;
        end
      end
    end
  end

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign oREGS[g*9 +: 9] = r_regs[g];
  end

  assign oREG_WE   = r_reg_we;
  assign oREG_ADDR = r_reg_addr;
  assign oREG_DATA = r_reg_data;
  assign oBAD_ADDR = r_bad_addr;
  assign oBUSY     = (r_state != ST_IDLE);
  assign oACTIVE   = r_regs[NUM_REGS-1][0];

endmodule
